// File: rtl/pe_pkg.sv
// Shared definitions for the systolic FIR processing element: default widths,
// signed range limits and the clamp/wrap helper used by the MAC datapath.
package pe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAC_W = 0;
  localparam int MAX_DATA_W = 64;
  localparam int SUM_W      = 2*MAX_DATA_W+1;

  localparam logic signed [DEF_DATA_W-1:0] MAX_POS = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] MAX_NEG = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  typedef struct packed {
    logic                  ovf;
    logic [MAX_DATA_W-1:0] val;
  } sat_res_t;

  // Callers keep only the low `width` bits of val; ovf flags any out-of-range sum.
  function automatic sat_res_t sat_trunc(input logic signed [SUM_W-1:0] sum,
                                         input int width,
                                         input logic saturate);
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sat_res_t res;
    one = {{(SUM_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (width-1)) - one;
    lo  = -(one <<< (width-1));
    res.ovf = (sum > hi) || (sum < lo);
    if (saturate && (sum > hi))
      res.val = hi[MAX_DATA_W-1:0];
    else if (saturate && (sum < lo))
      res.val = lo[MAX_DATA_W-1:0];
    else
      res.val = sum[MAX_DATA_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: y = d + ((w*x) >>> FRAC_W), clamped or wrapped.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int SATURATE = 1
) (
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] scaled;
  logic signed [2*DATA_W:0]   sum;
  logic signed [SUM_W-1:0]    sum_ext;
  sat_res_t                   res;
  logic                       unused_val;

  assign prod    = w * x;
  assign scaled  = prod >>> FRAC_W;
  // One guard bit above the product width makes the add overflow-free.
  assign sum     = (2*DATA_W+1)'(d) + (2*DATA_W+1)'(scaled);
  assign sum_ext = SUM_W'(sum);
  assign res     = sat_trunc(sum_ext, DATA_W, SATURATE != 0);

  assign y          = res.val[DATA_W-1:0];
  assign ovf        = res.ovf;
  assign unused_val = ^res.val;

endmodule

// File: rtl/process_element.sv
// Systolic FIR processing element: one registered MAC per cycle, w forwarded
// after one cycle and x after two so the next PE sees correctly skewed operands.
module process_element
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] w_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     ovf
);

  logic signed [DATA_W-1:0] y_p0;
  logic                     ovf_p0;
  logic signed [DATA_W-1:0] x_p1;

  pe_mac #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .w  (w),
    .x  (x),
    .d  (d),
    .y  (y_p0),
    .ovf(ovf_p0)
  );

  // Stage 1: MAC result, coefficient and first sample delay
  // Stage 2: second sample delay feeding x_out
  always_ff @(posedge clk) begin
    if (rst) begin
      x_p1  <= '0;
      x_out <= '0;
      w_out <= '0;
      y_out <= '0;
      ovf   <= 1'b0;
    end else begin
      x_p1  <= x;
      x_out <= x_p1;
      w_out <= w;
      y_out <= y_p0;
      ovf   <= ovf_p0;
    end
  end

endmodule

// File: tb/tb_process_element.sv
// Bench for process_element: three parameterisations share one input stream and
// are compared each cycle against an arithmetic reference of the PE behaviour.
module tb_process_element;

  logic               clk;
  logic               rst;
  logic signed [31:0] w, x, d;
  logic signed [31:0] x_out, w_out, y_out;
  logic               ovf;
  logic signed [31:0] x_out_w, w_out_w, y_out_w;
  logic               ovf_w;
  logic signed [31:0] x_out_f, w_out_f, y_out_f;
  logic               ovf_f;

  int tests = 0;
  int fails = 0;

  // Reference state: expected registered outputs and a queue of samples in flight
  logic signed [31:0] exp_y, exp_w, exp_x, exp_yw, exp_yf;
  logic               exp_o, exp_ow, exp_of;
  logic signed [31:0] xq[$];

  process_element #(.DATA_W(32), .FRAC_W(0), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .w(w), .x(x), .d(d),
    .x_out(x_out), .w_out(w_out), .y_out(y_out), .ovf(ovf));

  process_element #(.DATA_W(32), .FRAC_W(0), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .w(w), .x(x), .d(d),
    .x_out(x_out_w), .w_out(w_out_w), .y_out(y_out_w), .ovf(ovf_w));

  process_element #(.DATA_W(32), .FRAC_W(4), .SATURATE(1)) dut_frac (
    .clk(clk), .rst(rst), .w(w), .x(x), .d(d),
    .x_out(x_out_f), .w_out(w_out_f), .y_out(y_out_f), .ovf(ovf_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain 64-bit arithmetic reference: {ovf, y}
  function automatic logic [32:0] ref_mac(input logic signed [31:0] wi, xi, di,
                                          input int frac, input bit sat);
    longint p, s;
    p = longint'(wi) * longint'(xi);
    s = (p >>> frac) + longint'(di);
    if (s > 64'sd2147483647)
      return sat ? {1'b1, 32'h7fffffff} : {1'b1, s[31:0]};
    if (s < -64'sd2147483648)
      return sat ? {1'b1, 32'h80000000} : {1'b1, s[31:0]};
    return {1'b0, s[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(obs), obs, $signed(expv), expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y"},     y_out,            exp_y);
    chk({tag, "_ovf"},   {31'd0, ovf},     {31'd0, exp_o});
    chk({tag, "_wout"},  w_out,            exp_w);
    chk({tag, "_xout"},  x_out,            exp_x);
    chk({tag, "_yw"},    y_out_w,          exp_yw);
    chk({tag, "_ovfw"},  {31'd0, ovf_w},   {31'd0, exp_ow});
    chk({tag, "_yf"},    y_out_f,          exp_yf);
    chk({tag, "_ovff"},  {31'd0, ovf_f},   {31'd0, exp_of});
    chk({tag, "_xoutf"}, x_out_f,          exp_x);
    chk({tag, "_woutw"}, w_out_w,          exp_w);
  endtask

  // Apply inputs, take one rising edge, advance the reference, compare.
  task automatic step(input string tag, input logic r,
                      input logic signed [31:0] wi, xi, di);
    logic [32:0] m0, m1, m2;
    rst = r; w = wi; x = xi; d = di;
    @(posedge clk);
    #1;
    if (r) begin
      exp_y = 0; exp_o = 0; exp_w = 0; exp_x = 0;
      exp_yw = 0; exp_ow = 0; exp_yf = 0; exp_of = 0;
      xq = '{32'sd0};
    end else begin
      m0 = ref_mac(wi, xi, di, 0, 1'b1);
      m1 = ref_mac(wi, xi, di, 0, 1'b0);
      m2 = ref_mac(wi, xi, di, 4, 1'b1);
      exp_y  = m0[31:0]; exp_o  = m0[32];
      exp_yw = m1[31:0]; exp_ow = m1[32];
      exp_yf = m2[31:0]; exp_of = m2[32];
      exp_w  = wi;
      xq.push_back(xi);
      exp_x  = xq.pop_front();
    end
    check_all(tag);
  endtask

  initial begin
    logic signed [31:0] rw, rx, rd;
    rst = 1'b1; w = 0; x = 0; d = 0;

    // Reset release with constant operands
    step("t1_rst0", 1'b1, 32'sd22, -32'sd150, 32'sd69);
    step("t1_rst1", 1'b1, 32'sd22, -32'sd150, 32'sd69);
    chk("t1_rst_y", y_out, 32'd0);
    chk("t1_rst_x", x_out, 32'd0);
    step("t1_e1", 1'b0, 32'sd22, -32'sd150, 32'sd69);
    chk("t1_e1_y",    y_out,   -32'sd3231);
    chk("t1_e1_w",    w_out,   32'sd22);
    chk("t1_e1_x",    x_out,   32'sd0);
    chk("t1_e1_frac", y_out_f, -32'sd138);
    step("t1_e2", 1'b0, 32'sd22, -32'sd150, 32'sd69);
    chk("t1_e2_x", x_out, -32'sd150);
    for (int i = 0; i < 100; i++)
      step("t1_hold", 1'b0, 32'sd22, -32'sd150, 32'sd69);
    chk("t1_hold_y", y_out, -32'sd3231);

    // Ramp stream: y follows x by one cycle, x_out by two
    for (int i = 1; i <= 20; i++)
      step("t2_ramp", 1'b0, 32'sd1, 32'(i), 32'sd0);
    chk("t2_y_last", y_out, 32'sd20);
    chk("t2_x_last", x_out, 32'sd19);

    // Mid-stream reset, then refill
    step("t6_rst", 1'b1, 32'sd1, 32'sd21, 32'sd0);
    chk("t6_rst_x", x_out, 32'd0);
    chk("t6_rst_y", y_out, 32'd0);
    step("t6_r1", 1'b0, 32'sd1, 32'sd100, 32'sd0);
    chk("t6_r1_x", x_out, 32'd0);
    chk("t6_r1_y", y_out, 32'sd100);
    step("t6_r2", 1'b0, 32'sd1, 32'sd101, 32'sd0);
    chk("t6_r2_x", x_out, 32'sd100);

    // Positive saturation / wrap
    step("t3_pos", 1'b0, 32'sh7fffffff, 32'sh7fffffff, 32'sd1);
    chk("t3_sat_y",  y_out,   32'sh7fffffff);
    chk("t3_sat_o",  {31'd0, ovf},   32'd1);
    chk("t3_wrap_y", y_out_w, 32'sd2);
    chk("t3_wrap_o", {31'd0, ovf_w}, 32'd1);

    // Negative saturation then recovery
    step("t4_neg", 1'b0, 32'sh80000000, 32'sh7fffffff, -32'sd1);
    chk("t4_sat_y", y_out, 32'sh80000000);
    chk("t4_sat_o", {31'd0, ovf}, 32'd1);
    step("t4_rec", 1'b0, 32'sd0, 32'sd0, 32'sd5);
    chk("t4_rec_y", y_out, 32'sd5);
    chk("t4_rec_o", {31'd0, ovf}, 32'd0);

    // Randomised stream with occasional extreme operands
    for (int i = 0; i < 200; i++) begin
      rw = $urandom_range(0, 3) == 0 ? 32'sh80000000 : $signed($urandom);
      rx = $urandom_range(0, 3) == 0 ? 32'sh7fffffff : $signed($urandom);
      rd = $urandom_range(0, 1) == 0 ? $signed($urandom) : $signed(32'($urandom_range(0, 255)) - 32'sd128);
      if ($urandom_range(0, 2) == 0) begin
        rw = $signed(32'($urandom_range(0, 65535)) - 32'sd32768);
        rx = $signed(32'($urandom_range(0, 65535)) - 32'sd32768);
      end
      step("rnd", ($urandom_range(0, 49) == 0), rw, rx, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
